pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Central stall/flush controller for the five-stage pipeline. Each cycle it decides which stage registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) advance, hold or load a bubble. It covers load-use hazards, taken-branch/jump redirects, instruction-fetch wait and multi-cycle data-memory wait. A registered FSM tracks data-memory wait and enforces a timeout.

## Interface
Parameters:
- DMEM_TIMEOUT, 255: DWAIT cycles before dmem_timeout is raised (1..65535).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- ID_rs1, ID_rs2  in  5  source registers of the instruction in ID.
- ID_use_rs1, ID_use_rs2  in  1  ID instruction reads rs1/rs2.
- EX_rd  in  5  destination register of the EX instruction.
- EX_MemRead  in  1  EX instruction is a load.
- EX_redirect  in  1  EX resolved a taken branch or jump.
- MEM_mem_req  in  1  MEM instruction accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- imem_ready  in  1  instruction memory delivers fetch data this cycle.
- PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en  out  1  stage register samples its inputs.
- IF_ID_flush, ID_EX_flush, MEM_WB_flush  out  1  stage register loads a bubble: all-zero contents, RegWrite=0.
- dmem_timeout  out  1  sticky; set when DWAIT reaches DMEM_TIMEOUT.
- stall_cycles  out  32  count of cycles with PC_en=0 (perf build only).
- flush_count  out  32  count of redirects taken (perf build only).

## Operation
- Stage registers: flush overrides en. Asserting flush with en=0 still loads the bubble.
- FSM states:
  - RUN -> DWAIT when MEM_mem_req=1 and dmem_ready=0.
  - DWAIT -> RUN on dmem_ready=1.
  - DWAIT holds otherwise.
- Wait counter:
  - Cleared on entering DWAIT; increments each DWAIT cycle, saturating at DMEM_TIMEOUT.
  - On reaching DMEM_TIMEOUT, dmem_timeout is set. It stays set until reset.
  - The stall continues regardless of timeout.
- Priority, highest first. Evaluation is combinational each cycle:
  1. Dmem stall: (RUN and MEM_mem_req and !dmem_ready) or (DWAIT and !dmem_ready).
     - PC, IF/ID, ID/EX and EX/MEM hold.
     - MEM_WB_flush=1.
     - A pending EX_redirect is ignored. It is re-presented after the stall, because EX is held.
  2. Redirect (EX_redirect=1): all en=1, IF_ID_flush=1, ID_EX_flush=1. PC loads the target.
  3. Load-use: EX_MemRead, EX_rd!=0, and (ID_use_rs1 and ID_rs1==EX_rd, or ID_use_rs2 and ID_rs2==EX_rd).
     - PC and IF/ID hold.
     - ID_EX_flush=1.
     - EX/MEM and MEM/WB advance.
  4. Fetch wait (imem_ready=0): PC holds, IF_ID_flush=1, downstream stages advance.
  5. Otherwise: all en=1, all flush=0.
- Fetch wait coinciding with load-use: load-use applies; IF/ID holds, not flushed.
- Completion: dmem_ready=1 in DWAIT is a normal (non-stall) cycle, evaluated with rules 2-5.
- x0 destination: EX_rd=0 never triggers a load-use stall.

## Timing
- All en/flush outputs are combinational from inputs and current state, valid the same cycle. There is no added latency.
- State, wait counter, dmem_timeout and perf counters update on posedge clk.
- Load-use costs exactly one bubble. Redirect costs exactly two bubbles. A dmem wait of N not-ready cycles costs N stall cycles.
- Reset: asynchronous, active-high. While rst=1:
  - All en=0 and all flush=0.
  - State=RUN, wait counter=0, dmem_timeout=0, stall_cycles=0, flush_count=0.
- Reset asserted mid-DWAIT returns the FSM to RUN immediately. There is no pending-access memory.
- Perf counters wrap modulo 2^32.

## Configuration
- PIPE_HAZARD_CTRL_PERF_EN defined: stall_cycles and flush_count are live 32-bit counters.
- Not defined: both ports are tied to 32'b0 and the counter logic is absent. All other behaviour is identical.

## Test plan
- Load-use stall:
  - Stimulus: EX_MemRead=1, EX_rd=5, ID_rs1=5, ID_use_rs1=1, imem_ready=1.
  - Response: PC_en=0, IF_ID_en=0, ID_EX_flush=1, EX_MEM_en=1, for exactly one cycle.
  - Repeat with EX_rd=0: no stall.
- Redirect:
  - Stimulus: EX_redirect=1, no dmem stall.
  - Response: IF_ID_flush=1, ID_EX_flush=1, PC_en=1.
  - Perf build: flush_count goes 0->1.
- Dmem wait:
  - Stimulus: MEM_mem_req=1, dmem_ready low for 3 cycles, then high.
  - Response: PC/IF_ID/ID_EX/EX_MEM en=0 and MEM_WB_flush=1 for 3 cycles; then RUN with all en=1.
  - Perf build: stall_cycles=3.
- Redirect during dmem wait:
  - Stimulus: EX_redirect=1 held throughout the 2-cycle dmem stall.
  - Response: no flush during the stall; IF_ID_flush and ID_EX_flush assert in the cycle dmem_ready=1.
- Timeout:
  - Stimulus: DMEM_TIMEOUT=4, dmem_ready held 0 for 6 cycles.
  - Response: dmem_timeout rises after the 4th DWAIT cycle, stays 1 after dmem_ready=1, and clears only on rst.
- Reset mid-DWAIT:
  - Stimulus: assert rst during DWAIT.
  - Response: all outputs 0 immediately; after release with dmem_ready=1, state is RUN and all en=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the five-stage pipeline datapath and pipe_hazard_ctrl.
// master = pipeline side (drives hazard sources), slave = controller side (drives enables/flushes).
interface pipe_hazard_ctrl_if;
   logic [4:0]  ID_rs1;
   logic [4:0]  ID_rs2;
   logic        ID_use_rs1;
   logic        ID_use_rs2;
   logic [4:0]  EX_rd;
   logic        EX_MemRead;
   logic        EX_redirect;
   logic        MEM_mem_req;
   logic        dmem_ready;
   logic        imem_ready;
   logic        PC_en;
   logic        IF_ID_en;
   logic        ID_EX_en;
   logic        EX_MEM_en;
   logic        MEM_WB_en;
   logic        IF_ID_flush;
   logic        ID_EX_flush;
   logic        MEM_WB_flush;
   logic        dmem_timeout;
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;
   // Debug view of the dmem-wait FSM: 0 = RUN, 1 = DWAIT.
   logic        state_dbg;

   modport master (
      output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_rd, EX_MemRead,
             EX_redirect, MEM_mem_req, dmem_ready, imem_ready,
      input  PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
             IF_ID_flush, ID_EX_flush, MEM_WB_flush, dmem_timeout,
             stall_cycles, flush_count, state_dbg
   );

   modport slave (
      input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_rd, EX_MemRead,
             EX_redirect, MEM_mem_req, dmem_ready, imem_ready,
      output PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
             IF_ID_flush, ID_EX_flush, MEM_WB_flush, dmem_timeout,
             stall_cycles, flush_count, state_dbg
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline with a dmem-wait FSM and timeout flag.
// Define PIPE_HAZARD_CTRL_PERF_EN to build the stall_cycles/flush_count performance counters.
module pipe_hazard_ctrl #(
   parameter int unsigned DMEM_TIMEOUT = 255
) (
   input logic               clk,
   input logic               rst,
   pipe_hazard_ctrl_if.slave hz
);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DWAIT = 1'b1
   } state_e;

   localparam logic [15:0] TIMEOUT_LIM = 16'(DMEM_TIMEOUT);

   state_e      state_q, state_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        dmem_timeout_q, dmem_timeout_d;

   logic dmem_stall;
   logic load_use;
   logic redirect_take;
   logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic if_id_flush, id_ex_flush, mem_wb_flush;

   // Once in DWAIT the request is assumed still pending, so only dmem_ready matters.
   assign dmem_stall = ((state_q == ST_RUN) && hz.MEM_mem_req && !hz.dmem_ready) ||
                       ((state_q == ST_DWAIT) && !hz.dmem_ready);

   assign load_use = hz.EX_MemRead && (hz.EX_rd != 5'd0) &&
                     ((hz.ID_use_rs1 && (hz.ID_rs1 == hz.EX_rd)) ||
                      (hz.ID_use_rs2 && (hz.ID_rs2 == hz.EX_rd)));

   assign redirect_take = !rst && !dmem_stall && hz.EX_redirect;

   always_comb begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      if (rst) begin
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
         mem_wb_en = 1'b0;
      end else if (dmem_stall) begin
         // EX is frozen, so a pending redirect is simply seen again after the stall.
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (hz.EX_redirect) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         // Load-use wins over fetch wait: IF/ID holds its instruction instead of being flushed.
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end else if (!hz.imem_ready) begin
         pc_en       = 1'b0;
         if_id_flush = 1'b1;
      end
   end

   always_comb begin
      state_d        = state_q;
      wait_cnt_d     = wait_cnt_q;
      dmem_timeout_d = dmem_timeout_q;
      case (state_q)
         ST_RUN: begin
            if (hz.MEM_mem_req && !hz.dmem_ready) begin
               state_d    = ST_DWAIT;
               wait_cnt_d = 16'd0;
            end
         end
         ST_DWAIT: begin
            if (hz.dmem_ready) begin
               state_d = ST_RUN;
            end else begin
               // Only cycles still waiting count towards the timeout; the completion cycle does not.
               if (wait_cnt_q < TIMEOUT_LIM) begin
                  wait_cnt_d = wait_cnt_q + 16'd1;
               end
               if (wait_cnt_d == TIMEOUT_LIM) begin
                  dmem_timeout_d = 1'b1;
               end
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_RUN;
         wait_cnt_q     <= 16'd0;
         dmem_timeout_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         dmem_timeout_q <= dmem_timeout_d;
      end
   end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_count_q, flush_count_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (!pc_en) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
      if (redirect_take) begin
         flush_count_d = flush_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles_q <= 32'd0;
         flush_count_q  <= 32'd0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign hz.stall_cycles = stall_cycles_q;
   assign hz.flush_count  = flush_count_q;
`else
   logic unused_perf;
   assign unused_perf     = redirect_take;
   assign hz.stall_cycles = 32'b0;
   assign hz.flush_count  = 32'b0;
`endif

   assign hz.PC_en        = pc_en;
   assign hz.IF_ID_en     = if_id_en;
   assign hz.ID_EX_en     = id_ex_en;
   assign hz.EX_MEM_en    = ex_mem_en;
   assign hz.MEM_WB_en    = mem_wb_en;
   assign hz.IF_ID_flush  = if_id_flush;
   assign hz.ID_EX_flush  = id_ex_flush;
   assign hz.MEM_WB_flush = mem_wb_flush;
   assign hz.dmem_timeout = dmem_timeout_q;
   assign hz.state_dbg    = state_q;

endmodule
